// File: rtl/lsq_pkg.sv
// lsq_pkg -- shared types and constants for the load/store issue queue.
//   OP_LOAD / OP_STORE : the only opcodes the queue accepts
//   lsq_state_e        : issue FSM states (IDLE, REQ, WB)
//   lsq_entry_t        : one queued memory operation (op, addr, data, tag)
// The entry field widths are the storage widths of a queue slot; the
// lsq_mem_issue parameters must not exceed them.
package lsq_pkg;

  localparam int LSQ_OP_WIDTH      = 7;
  localparam int LSQ_OPRAND_WIDTH  = 32;
  localparam int LSQ_TAG_WIDTH     = 4;

  localparam logic [LSQ_OP_WIDTH-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } lsq_state_e;

  typedef struct packed {
    logic [LSQ_OP_WIDTH-1:0]     op;
    logic [LSQ_OPRAND_WIDTH-1:0] addr;
    logic [LSQ_OPRAND_WIDTH-1:0] data;
    logic [LSQ_TAG_WIDTH-1:0]    tag;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_fifo.sv
// lsq_fifo -- circular FIFO holding queued load/store entries.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   push_i, entry_i   write one entry at the tail (caller guarantees !full_o)
//   pop_i             drop the head entry (caller guarantees !empty_o)
//   head_o            entry at the head (valid when !empty_o)
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries, 0..DEPTH
module lsq_fifo
  import lsq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  lsq_entry_t               entry_i,
  input  logic                     pop_i,
  output lsq_entry_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lsq_entry_t             storage_q [DEPTH];
  logic [PTR_W-1:0]       wrPtr_q;
  logic [PTR_W-1:0]       rdPtr_q;
  logic [CNT_W-1:0]       count_q;

  // Slot contents need no reset: reset clears the pointers and count, so
  // stale slots are never observed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      storage_q[wrPtr_q] <= entry_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = storage_q[rdPtr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/lsq_mem_issue.sv
// lsq_mem_issue -- in-order load/store queue issuing to a single data-memory
// port and returning load results on a writeback port.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   enq_valid_i/enq_ready_o       enqueue handshake (ready = !full)
//   enq_op_i/addr_i/data_i/tag_i  operation to enqueue (LOAD/STORE kept)
//   mem_req_o/we_o/addr_o/wdata_o memory request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i        memory completion and load data
//   wb_valid_o/wb_ready_i         load writeback handshake
//   wb_tag_o, wb_data_o           load writeback tag and data
//   full_o, empty_o, count_o      queue occupancy
//   misalign_o                    one-cycle pulse when a misaligned entry is dropped
// Configuration macro: LSQ_MISALIGN_CHECK_EN enables the misaligned-address
// check; without it misalign_o is tied low and addresses issue unmodified.
module lsq_mem_issue
  import lsq_pkg::*;
#(
  parameter int OPRAND_WIDTH = 32,
  parameter int OP_WIDTH     = 7,
  parameter int TAG_WIDTH    = 4,
  parameter int DEPTH        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq_valid_i,
  output logic                      enq_ready_o,
  input  logic [OP_WIDTH-1:0]       enq_op_i,
  input  logic [OPRAND_WIDTH-1:0]   enq_addr_i,
  input  logic [OPRAND_WIDTH-1:0]   enq_data_i,
  input  logic [TAG_WIDTH-1:0]      enq_tag_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [OPRAND_WIDTH-1:0]   mem_addr_o,
  output logic [OPRAND_WIDTH-1:0]   mem_wdata_o,
  input  logic                      mem_ack_i,
  input  logic [OPRAND_WIDTH-1:0]   mem_rdata_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [TAG_WIDTH-1:0]      wb_tag_o,
  output logic [OPRAND_WIDTH-1:0]   wb_data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      misalign_o
);

  lsq_state_e                state_q, state_d;
  lsq_entry_t                enqEntry, headEntry;
  logic                      isMemOp, push, pop;
  logic                      fifoFull, fifoEmpty;
  logic                      headIsStore;
  logic [OPRAND_WIDTH-1:0]   headAddr;
  logic [TAG_WIDTH-1:0]      headTag;
  logic                      memWe_q, memWe_d;
  logic [OPRAND_WIDTH-1:0]   memAddr_q, memAddr_d;
  logic [OPRAND_WIDTH-1:0]   memWdata_q, memWdata_d;
  logic [OPRAND_WIDTH-1:0]   wbData_q, wbData_d;
  logic [TAG_WIDTH-1:0]      wbTag_q, wbTag_d;
`ifdef LSQ_MISALIGN_CHECK_EN
  logic                      misalign_q, misalign_d;
`endif

  // Non-memory opcodes complete the handshake but are discarded.
  assign isMemOp = (enq_op_i == OP_WIDTH'(OP_LOAD)) ||
                   (enq_op_i == OP_WIDTH'(OP_STORE));
  assign push    = enq_valid_i && enq_ready_o && isMemOp;

  always_comb begin
    enqEntry      = '0;
    enqEntry.op   = LSQ_OP_WIDTH'(enq_op_i);
    enqEntry.addr = LSQ_OPRAND_WIDTH'(enq_addr_i);
    enqEntry.data = LSQ_OPRAND_WIDTH'(enq_data_i);
    enqEntry.tag  = LSQ_TAG_WIDTH'(enq_tag_i);
  end

  lsq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (enqEntry),
    .pop_i   (pop),
    .head_o  (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (count_o)
  );

  assign headIsStore = (headEntry.op == OP_STORE);
  assign headAddr    = OPRAND_WIDTH'(headEntry.addr);
  assign headTag     = TAG_WIDTH'(headEntry.tag);

  // The head stays in the FIFO for the whole REQ phase and is popped on the
  // ack, so its tag is still readable when the load result is captured.
  always_comb begin
    state_d    = state_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    wbData_d   = wbData_q;
    wbTag_d    = wbTag_q;
    pop        = 1'b0;
`ifdef LSQ_MISALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
`ifdef LSQ_MISALIGN_CHECK_EN
          if (headEntry.addr[1:0] != 2'b00) begin
            pop        = 1'b1;
            misalign_d = 1'b1;
            if (!headIsStore) begin
              wbData_d = '0;
              wbTag_d  = headTag;
              state_d  = WB;
            end
          end else
`endif
          begin
            memAddr_d  = headAddr;
            memWdata_d = headIsStore ? OPRAND_WIDTH'(headEntry.data) : '0;
            memWe_d    = headIsStore;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          pop = 1'b1;
          if (memWe_q) begin
            state_d = IDLE;
          end else begin
            wbData_d = mem_rdata_i;
            wbTag_d  = headTag;
            state_d  = WB;
          end
        end
      end
      WB: begin
        if (wb_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      wbData_q   <= '0;
      wbTag_q    <= '0;
    end else begin
      state_q    <= state_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      wbData_q   <= wbData_d;
      wbTag_q    <= wbTag_d;
    end
  end

`ifdef LSQ_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  // Request and writeback strobes decode straight from the state register so
  // an asynchronous reset drops them in the same cycle.
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = (state_q == REQ) && memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;
  assign wb_valid_o  = (state_q == WB);
  assign wb_tag_o    = wbTag_q;
  assign wb_data_o   = wbData_q;
  assign full_o      = fifoFull;
  assign empty_o     = fifoEmpty;
  assign enq_ready_o = !fifoFull;

endmodule

// File: doc/lsq_mem_issue.md
LSQ_MEM_ISSUE -- requirements
Module: lsq_mem_issue

Interface
REQ-001 SHALL have parameter OPRAND_WIDTH, default 32, address/data width.
REQ-002 SHALL have parameter OP_WIDTH, default 7, opcode width.
REQ-003 SHALL have parameter TAG_WIDTH, default 4, writeback tag width.
REQ-004 SHALL have parameter DEPTH, default 4, queue entries, power of 2, minimum 2.
REQ-005 SHALL provide: clk  in  1  the one clock; all state changes on its rising edge.
REQ-006 SHALL provide: rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL provide: enq_valid_i in 1 / enq_ready_o out 1  enqueue handshake.
REQ-008 SHALL provide: enq_op_i in OP_WIDTH, enq_addr_i in OPRAND_WIDTH, enq_data_i in OPRAND_WIDTH (store data), enq_tag_i in TAG_WIDTH.
REQ-009 SHALL provide: mem_req_o out 1, mem_we_o out 1, mem_addr_o out OPRAND_WIDTH, mem_wdata_o out OPRAND_WIDTH, mem_ack_i in 1, mem_rdata_i in OPRAND_WIDTH  data-memory port.
REQ-010 SHALL provide: wb_valid_o out 1, wb_ready_i in 1, wb_tag_o out TAG_WIDTH, wb_data_o out OPRAND_WIDTH  load writeback.
REQ-011 SHALL provide: full_o out 1, empty_o out 1, count_o out $clog2(DEPTH)+1, misalign_o out 1.

Function
REQ-012 SHALL enqueue on enq_valid_i && enq_ready_o only when enq_op_i is LOAD (7'b0000011) or STORE (7'b0100011); other opcodes are accepted and discarded, with no state change.
REQ-013 SHALL drive enq_ready_o = !full_o; there is no same-cycle pass-through when full.
REQ-014 SHALL keep entries in FIFO order; read/write pointers wrap modulo DEPTH; count_o ranges 0..DEPTH.
REQ-015 SHALL run an FSM with states IDLE, REQ, WB.
REQ-016 IDLE: if queue not empty, latch the head into the memory output registers and go to REQ; mem_req_o is first high in cycle N+2 for an entry enqueued at the edge ending cycle N.
REQ-017 REQ: mem_req_o=1, mem_we_o=1 for STORE; mem_addr_o/mem_wdata_o/mem_we_o stay stable until mem_ack_i.
REQ-018 On mem_ack_i in REQ: pop the head; STORE goes to IDLE; LOAD captures mem_rdata_i into wb_data_o, the entry tag into wb_tag_o, and goes to WB.
REQ-019 WB: wb_valid_o=1 with data/tag stable until wb_ready_i; then go to IDLE.
REQ-020 SHALL ignore mem_ack_i outside REQ.
REQ-021 Simultaneous enqueue and pop SHALL leave count_o unchanged and both operations SHALL take effect.
REQ-022 mem_wdata_o SHALL be 0 for LOAD requests.

Reset
REQ-023 rst SHALL immediately clear pointers and count, set FSM=IDLE, and drive mem_req_o, mem_we_o, wb_valid_o, misalign_o, and all data/address/tag outputs to 0; empty_o=1, full_o=0, enq_ready_o=1.
REQ-024 Reset mid-transaction SHALL drop the in-flight and queued entries without completion.

Configuration
REQ-025 With LSQ_MISALIGN_CHECK_EN defined, a head entry with addr[1:0]!=0 SHALL skip REQ: it is popped in IDLE and misalign_o pulses high for 1 cycle. A STORE is dropped; a LOAD goes to WB with wb_data_o=0.
REQ-026 Without LSQ_MISALIGN_CHECK_EN, the port SHALL still exist, misalign_o SHALL be tied 0, and every address SHALL be issued unmodified.

Structure
REQ-027 Package lsq_pkg SHALL hold the LOAD/STORE opcode constants, the FSM state enum, and the queue entry struct (op, addr, data, tag).
REQ-028 Queue storage and pointers SHALL be in sub-module lsq_fifo; the FSM and ports SHALL be in lsq_mem_issue.

Verification
REQ-029 Enqueue STORE addr 0x100, data 0xDEADBEEF, ack after 3 cycles -> mem_req_o high 3 cycles, mem_we_o=1, addr/data stable, no wb_valid_o.
REQ-030 Enqueue LOAD addr 0x200, tag 5, rdata 0x12345678, wb_ready_i low 2 cycles -> wb_valid_o held until ready, wb_tag_o=5, wb_data_o=0x12345678.
REQ-031 Enqueue 4 entries with mem_ack_i held low -> full_o=1, count_o=4, enq_ready_o=0; a fifth enqueue is refused; entries then issue in order.
REQ-032 Enqueue opcode 7'b0110011 -> count_o unchanged, no memory request.
REQ-033 Assert rst during REQ -> mem_req_o=0 the same cycle, empty_o=1; the next enqueue issues normally.
REQ-034 With LSQ_MISALIGN_CHECK_EN, LOAD addr 0x103 tag 2 -> no mem_req_o, misalign_o 1-cycle pulse, wb_data_o=0, wb_tag_o=2.
